// File: rtl/amds_pkg.sv
// -----------------------------------------------------------------------------
// amds_pkg
//   Shared definitions for the AMDS trigger controller slice.
//   - state_e    : sequencer states
//   - CNT_W_DEF  : default width of timing config, counters and latency
//   - NUM_RX_DEF : default number of downstream UART data receivers
// -----------------------------------------------------------------------------
package amds_pkg;

  localparam int CNT_W_DEF  = 16;
  localparam int NUM_RX_DEF = 2;

  // One pass through SYNC -> DELAY -> ARM -> WAIT_DONE per accepted trigger.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SYNC      = 3'd1,
    ST_DELAY     = 3'd2,
    ST_ARM       = 3'd3,
    ST_WAIT_DONE = 3'd4
  } state_e;

endpackage : amds_pkg

// File: rtl/amds_trigger_ctrl_if.sv
// -----------------------------------------------------------------------------
// amds_trigger_ctrl_if
//   Bundles the trigger/config inputs, the receiver handshake and the status
//   outputs of amds_trigger_ctrl.
//   Modports:
//     master : the trigger controller (drives sync_out, start_rx and status)
//     slave  : the environment (timing manager, register block, receivers)
//   Signals:
//     enable, trigger_in                       trigger acceptance
//     sync_width, rx_delay, timeout_cycles     timing config (CNT_W each)
//     rx_done[NUM_RX]                          receiver done levels
//     sync_out, start_rx[NUM_RX]               AMDS sync line, receiver start
//     busy, all_done_pulse, timed_out          sequence status
//     last_latency, counter_missed_trigger,
//     counter_timeout                          statistics (CNT_W each)
// -----------------------------------------------------------------------------
interface amds_trigger_ctrl_if
  import amds_pkg::*;
#(
  parameter int NUM_RX = NUM_RX_DEF,
  parameter int CNT_W  = CNT_W_DEF
);

  logic              enable;
  logic              trigger_in;
  logic [CNT_W-1:0]  sync_width;
  logic [CNT_W-1:0]  rx_delay;
  logic [CNT_W-1:0]  timeout_cycles;
  logic [NUM_RX-1:0] rx_done;

  logic              sync_out;
  logic [NUM_RX-1:0] start_rx;
  logic              busy;
  logic              all_done_pulse;
  logic              timed_out;
  logic [CNT_W-1:0]  last_latency;
  logic [CNT_W-1:0]  counter_missed_trigger;
  logic [CNT_W-1:0]  counter_timeout;

  modport master (
    input  enable, trigger_in, sync_width, rx_delay, timeout_cycles, rx_done,
    output sync_out, start_rx, busy, all_done_pulse, timed_out,
           last_latency, counter_missed_trigger, counter_timeout
  );

  modport slave (
    output enable, trigger_in, sync_width, rx_delay, timeout_cycles, rx_done,
    input  sync_out, start_rx, busy, all_done_pulse, timed_out,
           last_latency, counter_missed_trigger, counter_timeout
  );

endinterface : amds_trigger_ctrl_if

// File: rtl/amds_trigger_ctrl.sv
// -----------------------------------------------------------------------------
// amds_trigger_ctrl
//   Upstream sequencer for the AMDS UART data receivers. For every accepted
//   trigger it pulses the AMDS sync line for sync_width cycles, waits rx_delay
//   cycles, broadcasts a one-cycle start_rx to all receivers and then waits for
//   every receiver's done level (optionally bounded by a watchdog).
//   Ports:
//     clk    : clock
//     rst_n  : asynchronous active-low reset
//     bus    : amds_trigger_ctrl_if.master (trigger/config in, receiver
//              handshake, status and statistics out)
//   All outputs come straight from flops.
// -----------------------------------------------------------------------------
module amds_trigger_ctrl
  import amds_pkg::*;
#(
  parameter int NUM_RX = NUM_RX_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  amds_trigger_ctrl_if.master  bus
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;         // phase counter, reused per state
  logic [CNT_W-1:0]  lat_q, lat_d;         // trigger-to-end latency
  logic [CNT_W-1:0]  width_q, width_d;     // shadow config, frozen at accept
  logic [CNT_W-1:0]  delay_q, delay_d;
  logic [CNT_W-1:0]  tmo_q, tmo_d;
  logic              sync_q, sync_d;
  logic [NUM_RX-1:0] start_q, start_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              timed_out_q, timed_out_d;
  logic [CNT_W-1:0]  last_lat_q, last_lat_d;
  logic [CNT_W-1:0]  missed_q, missed_d;
  logic [CNT_W-1:0]  to_cnt_q, to_cnt_d;

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_d       = lat_q;
    width_d     = width_q;
    delay_d     = delay_q;
    tmo_d       = tmo_q;
    sync_d      = sync_q;
    start_d     = '0;          // start_rx is a pulse: low unless set below
    busy_d      = busy_q;
    done_d      = 1'b0;        // all_done_pulse is a pulse as well
    timed_out_d = timed_out_q;
    last_lat_d  = last_lat_q;
    missed_d    = missed_q;
    to_cnt_d    = to_cnt_q;

    // Any trigger outside IDLE is dropped and counted, including the cycle in
    // which the sequence completes (the FSM is still in WAIT_DONE then).
    if (state_q != ST_IDLE && bus.trigger_in) begin
      missed_d = missed_q + ONE;
    end

    // Latency saturates rather than wrapping so a stuck sequence reads as max.
    if (busy_q && lat_q != '1) begin
      lat_d = lat_q + ONE;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (bus.enable && bus.trigger_in) begin
          width_d = (bus.sync_width == '0) ? ONE : bus.sync_width;
          delay_d = bus.rx_delay;
          tmo_d   = bus.timeout_cycles;
          cnt_d   = '0;
          lat_d   = '0;
          sync_d  = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_SYNC;
        end
      end

      ST_SYNC: begin
        if (cnt_q == width_q - ONE) begin
          sync_d  = 1'b0;
          cnt_d   = '0;
          state_d = ST_DELAY;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end

      ST_DELAY: begin
        if (cnt_q == delay_q) begin
          start_d = '1;
          cnt_d   = '0;
          state_d = ST_ARM;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end

      // start_rx is high during this cycle; receivers drop done on the edge
      // that ends it, so rx_done is stale here and deliberately not looked at.
      ST_ARM: begin
        state_d = ST_WAIT_DONE;
      end

      ST_WAIT_DONE: begin
        if (&bus.rx_done) begin
          // Done has priority over a watchdog expiring in the same cycle.
          done_d      = 1'b1;
          timed_out_d = 1'b0;
          last_lat_d  = lat_q;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end else if (tmo_q != '0 && cnt_q == tmo_q - ONE) begin
          done_d      = 1'b1;
          timed_out_d = 1'b1;
          to_cnt_d    = to_cnt_q + ONE;
          last_lat_d  = lat_q;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: the shadow config is reset along with everything else; it is a
  // handful of flops, not a memory, and a defined value keeps lint and
  // equivalence checks quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      lat_q       <= '0;
      width_q     <= '0;
      delay_q     <= '0;
      tmo_q       <= '0;
      sync_q      <= 1'b0;
      start_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timed_out_q <= 1'b0;
      last_lat_q  <= '0;
      missed_q    <= '0;
      to_cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values computed above, independent of statement order.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_q       <= lat_d;
      width_q     <= width_d;
      delay_q     <= delay_d;
      tmo_q       <= tmo_d;
      sync_q      <= sync_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timed_out_q <= timed_out_d;
      last_lat_q  <= last_lat_d;
      missed_q    <= missed_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  assign bus.sync_out               = sync_q;
  assign bus.start_rx               = start_q;
  assign bus.busy                   = busy_q;
  assign bus.all_done_pulse         = done_q;
  assign bus.timed_out              = timed_out_q;
  assign bus.last_latency           = last_lat_q;
  assign bus.counter_missed_trigger = missed_q;
  assign bus.counter_timeout        = to_cnt_q;

endmodule : amds_trigger_ctrl

// File: tb/tb_amds_trigger_ctrl.sv
// -----------------------------------------------------------------------------
// tb_amds_trigger_ctrl
//   Scoreboard bench for amds_trigger_ctrl. Each issued sequence pushes its
//   expected outcome (computed in closed form from the configured timing and
//   the planned receiver behaviour); a monitor tracks sync/start activity and
//   compares everything when the completion pulse is due.
// -----------------------------------------------------------------------------
module tb_amds_trigger_ctrl;
  import amds_pkg::*;

  localparam int NUM_RX = NUM_RX_DEF;
  localparam int CNT_W  = CNT_W_DEF;
  localparam logic [NUM_RX-1:0] ALL_ONES = '1;

  typedef struct {
    int sync_rise;
    int sync_len;
    int start_c;
    int pulse_c;
    int tmo;
    int lat;
    int missed;
    int to_cnt;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  amds_trigger_ctrl_if #(.NUM_RX(NUM_RX), .CNT_W(CNT_W)) bus ();

  amds_trigger_ctrl #(.NUM_RX(NUM_RX), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t exp_q[$];
  int   exp_missed  = 0;
  int   exp_to      = 0;
  int   hold[NUM_RX];      // receiver busy length after start; <0 = stuck
  bit   rel         = 0;   // releases a stuck receiver

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit in_q(input int q[$], input int v);
    foreach (q[i]) if (q[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------------------------------------------------------------------
  // Receiver emulation: done drops in the cycle after start_rx and returns
  // after hold[i] cycles (or when released, if stuck).
  // ---------------------------------------------------------------------------
  initial begin
    automatic int left[NUM_RX];
    automatic bit saw;
    bus.rx_done = '1;
    forever begin
      @(negedge clk);
      saw = rst_n && (bus.start_rx != '0);
      @(posedge clk);
      #1;
      if (!rst_n) begin
        bus.rx_done = '1;
      end else if (saw) begin
        for (int i = 0; i < NUM_RX; i++) begin
          bus.rx_done[i] = 1'b0;
          left[i] = hold[i];
        end
      end else begin
        for (int i = 0; i < NUM_RX; i++) begin
          if (!bus.rx_done[i]) begin
            if (hold[i] < 0) begin
              if (rel) bus.rx_done[i] = 1'b1;
            end else begin
              left[i]--;
              if (left[i] <= 0) bus.rx_done[i] = 1'b1;
            end
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  int          trk_rise, trk_len, trk_start, trk_cnt, trk_busy;
  logic [NUM_RX-1:0] trk_val;
  bit          prev_sync;
  exp_t        mon_e;

  task automatic trk_clear();
    trk_rise = -1; trk_len = 0; trk_start = -1; trk_cnt = 0;
    trk_busy = 0;  trk_val = '0;
  endtask

  initial begin
    trk_clear();
    prev_sync = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        trk_clear();
        prev_sync = 1'b0;
      end else begin
        if (bus.sync_out) begin
          if (!prev_sync) trk_rise = cyc;
          trk_len++;
        end
        prev_sync = bus.sync_out;
        if (bus.start_rx != '0) begin
          trk_start = cyc;
          trk_val   = bus.start_rx;
          trk_busy  = int'(bus.busy);
          trk_cnt++;
        end
        if (exp_q.size() > 0 && cyc == exp_q[0].pulse_c) begin
          mon_e = exp_q.pop_front();
          check("all_done_pulse", bus.all_done_pulse, 1);
          check("sync_rise",      trk_rise,  mon_e.sync_rise);
          check("sync_len",       trk_len,   mon_e.sync_len);
          check("start_cycle",    trk_start, mon_e.start_c);
          check("start_count",    trk_cnt,   1);
          check("start_value",    trk_val,   ALL_ONES);
          check("busy_at_start",  trk_busy,  1);
          check("busy_at_end",    bus.busy,  0);
          check("timed_out",      bus.timed_out, mon_e.tmo);
          check("last_latency",   bus.last_latency, mon_e.lat);
          check("missed_count",   bus.counter_missed_trigger, mon_e.missed);
          check("timeout_count",  bus.counter_timeout, mon_e.to_cnt);
          trk_clear();
        end else if (bus.all_done_pulse) begin
          check("spurious_pulse", bus.all_done_pulse, 0);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // One trigger sequence. Called in the cycle the trigger is to be presented.
  // ---------------------------------------------------------------------------
  task automatic run_seq(input int w, input int d, input int to, input int l0,
                         input int l1, input int nmiss, input int newd,
                         input bit drop_en);
    int   wp, t, a, maxl, end_c, drop_at, tries, v;
    int   tmo;
    int   miss_q[$];
    exp_t e;

    wp = (w == 0) ? 1 : w;
    bus.sync_width     = CNT_W'(w);
    bus.rx_delay       = CNT_W'(d);
    bus.timeout_cycles = CNT_W'(to);
    bus.enable         = 1'b1;
    bus.trigger_in     = 1'b1;
    hold[0] = l0;
    hold[1] = l1;
    t = cyc;

    // Start pulse cycle: W sync cycles, one turnaround, D delay cycles, one more.
    a    = t + wp + 2 + d;
    maxl = (l0 < 0 || l1 < 0) ? 1000000 : ((l0 > l1) ? l0 : l1);
    // All receivers are done again in cycle a+maxl+1; the watchdog fires in
    // cycle a+to. Done wins a tie.
    if (to != 0 && to <= maxl) begin
      end_c = a + to;
      tmo   = 1;
    end else begin
      end_c = a + maxl + 1;
      tmo   = 0;
    end

    if (nmiss > 0) miss_q.push_back(end_c);
    tries = 0;
    while (miss_q.size() < nmiss && tries < 200) begin
      v = $urandom_range(end_c - 1, t + 1);
      if (!in_q(miss_q, v)) miss_q.push_back(v);
      tries++;
    end

    exp_missed += miss_q.size();
    if (tmo != 0) exp_to++;
    e.sync_rise = t + 1;
    e.sync_len  = wp;
    e.start_c   = a;
    e.pulse_c   = end_c + 1;
    e.tmo       = tmo;
    e.lat       = end_c - t - 1;
    e.missed    = exp_missed;
    e.to_cnt    = exp_to;
    exp_q.push_back(e);

    drop_at = drop_en ? int'($urandom_range(end_c, t + 1)) : -1;
    for (int c = t + 1; c <= end_c; c++) begin
      step();
      bus.trigger_in = in_q(miss_q, c);
      if (c == t + 1) begin
        bus.sync_width     = CNT_W'($urandom);
        bus.rx_delay       = (newd >= 0) ? CNT_W'(newd) : CNT_W'($urandom);
        bus.timeout_cycles = CNT_W'($urandom);
      end
      if (c == drop_at) bus.enable = 1'b0;
    end
    step();
    bus.trigger_in = 1'b0;
    bus.enable     = 1'b1;
    rel = 1'b1;
    repeat (2) step();
    rel = 1'b0;
    repeat ($urandom_range(4, 1)) step();
  endtask

  // Trigger a W=4/D=10 sequence and pull reset k cycles after acceptance.
  task automatic reset_mid(input int k);
    bus.sync_width     = CNT_W'(4);
    bus.rx_delay       = CNT_W'(10);
    bus.timeout_cycles = '0;
    bus.enable         = 1'b1;
    bus.trigger_in     = 1'b1;
    hold[0] = 5;
    hold[1] = 5;
    step();
    bus.trigger_in = 1'b0;
    repeat (k - 1) step();
    #1;
    check("pre_reset_busy", bus.busy, 1);
    if (k <= 4)  check("pre_reset_sync", bus.sync_out, 1);
    if (k == 16) check("pre_reset_start", bus.start_rx, ALL_ONES);
    rst_n = 1'b0;
    #1;
    check("rst_sync_out",  bus.sync_out, 0);
    check("rst_start_rx",  bus.start_rx, 0);
    check("rst_busy",      bus.busy, 0);
    check("rst_missed",    bus.counter_missed_trigger, 0);
    check("rst_timeouts",  bus.counter_timeout, 0);
    check("rst_latency",   bus.last_latency, 0);
    check("rst_timed_out", bus.timed_out, 0);
    exp_q.delete();
    exp_missed = 0;
    exp_to     = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) step();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    bus.enable         = 1'b0;
    bus.trigger_in     = 1'b0;
    bus.sync_width     = '0;
    bus.rx_delay       = '0;
    bus.timeout_cycles = '0;
    hold[0] = 1;
    hold[1] = 1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_sync_out",  bus.sync_out, 0);
    check("reset_start_rx",  bus.start_rx, 0);
    check("reset_busy",      bus.busy, 0);
    check("reset_done",      bus.all_done_pulse, 0);
    check("reset_timed_out", bus.timed_out, 0);
    check("reset_latency",   bus.last_latency, 0);
    check("reset_missed",    bus.counter_missed_trigger, 0);
    check("reset_timeouts",  bus.counter_timeout, 0);
    rst_n = 1'b1;
    repeat (2) step();

    // Directed sequences: w, d, to, l0, l1, nmiss, newd, drop_en
    run_seq(4, 10, 0, 200, 200, 0, -1, 0);   // normal
    run_seq(0, 0, 0, 3, 7, 0, -1, 0);        // zero width / delay
    run_seq(3, 5, 50, 5, -1, 0, -1, 0);      // watchdog, rx_done[1] stuck
    run_seq(2, 4, 0, 6, 9, 0, -1, 0);        // clears timed_out
    run_seq(4, 10, 0, 20, 15, 3, -1, 0);     // three missed triggers
    run_seq(4, 10, 0, 8, 8, 0, 100, 0);      // rx_delay 10->100 mid-sequence
    run_seq(1, 2, 21, 10, 20, 1, -1, 0);     // done and watchdog tie
    run_seq(5, 3, 0, 12, 4, 2, -1, 1);       // enable falls mid-sequence

    // Trigger in IDLE with enable low: ignored, not counted.
    bus.enable     = 1'b0;
    bus.trigger_in = 1'b1;
    step();
    bus.trigger_in = 1'b0;
    repeat (4) begin
      step();
      check("disabled_sync", bus.sync_out, 0);
      check("disabled_busy", bus.busy, 0);
    end
    check("disabled_missed", bus.counter_missed_trigger, exp_missed);
    bus.enable = 1'b1;

    // Randomized sequences.
    for (int s = 0; s < 12; s++) begin
      automatic int to = ($urandom_range(2, 0) == 0) ? 0 : int'($urandom_range(40, 1));
      automatic int l0 = $urandom_range(30, 1);
      automatic int l1 = $urandom_range(30, 1);
      if (to != 0 && $urandom_range(3, 0) == 0) l1 = -1;
      run_seq($urandom_range(6, 0), $urandom_range(12, 0), to, l0, l1,
              $urandom_range(3, 0), -1, 1'($urandom_range(1, 0)));
    end

    // Reset during SYNC, DELAY and ARM, each followed by a clean run.
    reset_mid(2);
    run_seq(2, 3, 0, 4, 4, 0, -1, 0);
    reset_mid(8);
    run_seq(4, 10, 0, 10, 12, 1, -1, 0);
    reset_mid(16);
    run_seq(3, 1, 30, 5, 6, 0, -1, 0);

    repeat (5) step();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule : tb_amds_trigger_ctrl

// File: doc/amds_trigger_ctrl.md
Name: amds_trigger_ctrl

Overview:
- Upstream sequencer for the AMDS UART data receivers.
- On each accepted PWM-synchronous trigger it drives the sync line to the AMDS and waits a programmable settle delay. It then issues a one-cycle start_rx to all receivers and waits for every receiver's done level.
- Reports completion, trigger-to-done latency, missed-trigger and watchdog-timeout counts to the register interface.

Parameters:
- NUM_RX, 2, number of downstream receivers (one per AMDS data line).
- CNT_W, 16, width of all timing config inputs, counters and latency output.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  accept triggers when 1.
- trigger_in  in  1  single-cycle trigger pulse from the timing manager.
- sync_width  in  CNT_W  sync_out high time in cycles; 0 is treated as 1.
- rx_delay  in  CNT_W  cycles between sync_out fall and start_rx.
- timeout_cycles  in  CNT_W  watchdog limit in WAIT_DONE; 0 disables it.
- rx_done  in  NUM_RX  done levels from the receivers (1 at idle/reset).
- sync_out  out  1  registered sync/convert line to the AMDS.
- start_rx  out  NUM_RX  registered one-cycle start pulse, broadcast to all bits.
- busy  out  1  sequence in progress.
- all_done_pulse  out  1  one cycle at sequence end (normal or timeout).
- timed_out  out  1  status of the last sequence: 1 = watchdog abort.
- last_latency  out  CNT_W  cycles from trigger acceptance to sequence end, saturating.
- counter_missed_trigger  out  CNT_W  triggers ignored while busy; wraps.
- counter_timeout  out  CNT_W  watchdog aborts; wraps.

Behaviour:
- Reset values: all outputs 0, state IDLE, shadow config 0.
- Trigger acceptance:
  - Accepted only in IDLE with enable=1 (cycle T).
  - On acceptance: latch shadow copies of sync_width (0→1), rx_delay and timeout_cycles; cnt←0; lat←0; sync_out←1; busy←1; state←SYNC.
  - Mid-sequence config changes have no effect.
- Missed triggers: trigger_in=1 in any state other than IDLE → counter_missed_trigger+1.
  - This includes the completion cycle.
  - Trigger with enable=0 in IDLE is ignored and not counted.
- lat increments every cycle while busy and saturates at all ones.
- States:
  - IDLE: as above.
  - SYNC:
    - cnt+1 each cycle.
    - When cnt==W-1: sync_out←0, cnt←0, →DELAY.
    - sync_out is high exactly W cycles, T+1..T+W.
  - DELAY:
    - If cnt==rx_delay: start_rx←all ones, cnt←0, →ARM.
    - Otherwise cnt+1.
    - start_rx is high in cycle T+W+2+D (D = rx_delay).
  - ARM:
    - start_rx high this cycle only; start_rx←0; →WAIT_DONE.
    - rx_done is ignored here, because receivers clear done on this edge.
  - WAIT_DONE, normal end:
    - If &rx_done: all_done_pulse←1, timed_out←0, last_latency←lat, busy←0, →IDLE.
  - WAIT_DONE, watchdog end:
    - Else if shadow timeout≠0 and cnt==timeout-1: all_done_pulse←1, timed_out←1, counter_timeout+1, last_latency←lat, busy←0, →IDLE.
    - Otherwise cnt+1.
- enable falling mid-sequence does not abort; the sequence completes.
- Reset mid-sequence: immediate return to reset values. sync_out and start_rx drop asynchronously.
- If done and timeout fire in the same cycle, done wins (timed_out=0).
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package amds_pkg holds:
  - state enum (IDLE, SYNC, DELAY, ARM, WAIT_DONE);
  - CNT_W default;
  - NUM_RX default.
- No sub-module is warranted: one FSM, one phase counter, one latency counter, two event counters.

Test Plan:
- Normal sequence: sync_width=4, rx_delay=10, rx_done drops 1 cycle after start_rx and returns after 200 cycles → sync_out high T+1..T+4; start_rx=2'b11 only at T+16; all_done_pulse fires and last_latency=lat at completion; timed_out=0.
- Zero widths: sync_width=0, rx_delay=0 → sync_out high 1 cycle (T+1); start_rx at T+3.
- Watchdog: timeout_cycles=50, rx_done[1] stuck 0 → all_done_pulse and timed_out=1 exactly 50 cycles after ARM; counter_timeout=1; next normal run clears timed_out.
- Missed triggers: 3 trigger pulses while busy, including one in the completion cycle → counter_missed_trigger=3; sequence timing unchanged. A trigger with enable=0 in IDLE → no count, no sync_out.
- Config change mid-sequence: rx_delay changed 10→100 during SYNC → start_rx still at T+W+12.
- Reset mid-sequence: rst_n low during DELAY → sync_out, start_rx, busy = 0 immediately; counters 0; the next trigger runs a clean sequence.
